// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared definitions for the RV32I fetch stage.
//   Default widths, reset vector and memory decode size, the canonical NOP
//   (addi x0,x0,0), and the selector enums used by the PC and IF/ID logic.
package if_stage_pkg;

  localparam int unsigned PC_W          = 32;
  localparam int unsigned INST_W        = 32;
  localparam int unsigned CNT_W         = 32;
  localparam int unsigned MEM_ADDR_BITS_DEF = 20;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  // Source of the next PC value.
  typedef enum logic [1:0] {
    PC_SEL_INC    = 2'd0,
    PC_SEL_HOLD   = 2'd1,
    PC_SEL_TARGET = 2'd2
  } pc_sel_e;

  // Action applied to the IF/ID register on the next edge.
  typedef enum logic [1:0] {
    IFID_LOAD  = 2'd0,
    IFID_HOLD  = 2'd1,
    IFID_FLUSH = 2'd2
  } ifid_op_e;

endpackage : if_stage_pkg

// File: rtl/if_stage_if.sv
// if_stage_if: bundle of the fetch stage's control inputs, memory port and
//   IF/ID outputs.
//   master: the environment (hazard unit, EX redirect, instruction memory)
//   slave : the fetch stage itself
//   Inputs : stall_i, flush_i, redirect_i, target_i, inst_i
//   Outputs: pc_o, ifid_valid_o, ifid_inst_o, ifid_pc_o, ifid_pc4_o,
//            ifid_fault_o, fetch_cnt_o
interface if_stage_if
  import if_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH_LENGTH   = PC_W,
  parameter int unsigned INST_WIDTH_LENGTH = INST_W
);
  logic                         stall_i;
  logic                         flush_i;
  logic                         redirect_i;
  logic [PC_WIDTH_LENGTH-1:0]   target_i;
  logic [INST_WIDTH_LENGTH-1:0] inst_i;
  logic [PC_WIDTH_LENGTH-1:0]   pc_o;
  logic                         ifid_valid_o;
  logic [INST_WIDTH_LENGTH-1:0] ifid_inst_o;
  logic [PC_WIDTH_LENGTH-1:0]   ifid_pc_o;
  logic [PC_WIDTH_LENGTH-1:0]   ifid_pc4_o;
  logic                         ifid_fault_o;
  logic [CNT_W-1:0]             fetch_cnt_o;

  modport master (
    output stall_i, flush_i, redirect_i, target_i, inst_i,
    input  pc_o, ifid_valid_o, ifid_inst_o, ifid_pc_o, ifid_pc4_o,
           ifid_fault_o, fetch_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, redirect_i, target_i, inst_i,
    output pc_o, ifid_valid_o, ifid_inst_o, ifid_pc_o, ifid_pc4_o,
           ifid_fault_o, fetch_cnt_o
  );
endinterface : if_stage_if

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register. Priority flush > stall > load.
//   flush_i : squash to a bubble (valid=0, NOP, zero addresses, no fault)
//   stall_i : hold every field
//   load    : capture fetched instruction; a faulting fetch loads NOP with
//             fault set, since the memory data is meaningless in that case
//   Inputs : fault_i, inst_i, pc_i, pc4_i
//   Outputs: valid_o, inst_o, pc_o, pc4_o, fault_o (all registered)
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH_LENGTH   = PC_W,
  parameter int unsigned INST_WIDTH_LENGTH = INST_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         stall_i,
  input  logic                         fault_i,
  input  logic [INST_WIDTH_LENGTH-1:0] inst_i,
  input  logic [PC_WIDTH_LENGTH-1:0]   pc_i,
  input  logic [PC_WIDTH_LENGTH-1:0]   pc4_i,
  output logic                         valid_o,
  output logic [INST_WIDTH_LENGTH-1:0] inst_o,
  output logic [PC_WIDTH_LENGTH-1:0]   pc_o,
  output logic [PC_WIDTH_LENGTH-1:0]   pc4_o,
  output logic                         fault_o
);

  localparam logic [INST_WIDTH_LENGTH-1:0] NOP = INST_WIDTH_LENGTH'(NOP_INST);

  ifid_op_e                     op_s;
  logic                         valid_d, valid_q;
  logic [INST_WIDTH_LENGTH-1:0] inst_d, inst_q;
  logic [PC_WIDTH_LENGTH-1:0]   pc_d, pc_q;
  logic [PC_WIDTH_LENGTH-1:0]   pc4_d, pc4_q;
  logic                         fault_d, fault_q;

  // Select register action by priority.
  always_comb begin
    op_s = IFID_LOAD;
    if (flush_i) begin
      op_s = IFID_FLUSH;
    end else if (stall_i) begin
      op_s = IFID_HOLD;
    end else begin
      op_s = IFID_LOAD;
    end
  end

  // Next-state values for every IF/ID field.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    fault_d = fault_q;
    case (op_s)
      IFID_FLUSH: begin
        valid_d = 1'b0;
        inst_d  = NOP;
        pc_d    = '0;
        pc4_d   = '0;
        fault_d = 1'b0;
      end
      IFID_HOLD: begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        fault_d = fault_q;
      end
      IFID_LOAD: begin
        valid_d = 1'b1;
        inst_d  = fault_i ? NOP : inst_i;
        pc_d    = pc_i;
        pc4_d   = pc4_i;
        fault_d = fault_i;
      end
      default: begin
        valid_d = 1'b0;
        inst_d  = NOP;
        pc_d    = '0;
        pc4_d   = '0;
        fault_d = 1'b0;
      end
    endcase
  end

  // IF/ID state flops with asynchronous reset to a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= NOP;
      pc_q    <= '0;
      pc4_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      fault_q <= fault_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign fault_o = fault_q;

endmodule : if_id_reg

// File: rtl/if_stage.sv
// if_stage: RV32I instruction-fetch stage.
//   Owns the PC (drives the instruction memory address), classifies the
//   current fetch as faulting when misaligned or beyond the decoded memory,
//   and feeds the IF/ID register. Counts instructions accepted into IF/ID.
//   Ports: clk, rst_n (async active-low), bus (if_stage_if.slave):
//     in : stall_i, flush_i, redirect_i, target_i, inst_i
//     out: pc_o, ifid_valid_o, ifid_inst_o, ifid_pc_o, ifid_pc4_o,
//          ifid_fault_o, fetch_cnt_o
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned          PC_WIDTH_LENGTH   = PC_W,
  parameter int unsigned          INST_WIDTH_LENGTH = INST_W,
  parameter logic [PC_W-1:0]      RESET_VECTOR      = RESET_VECTOR_DEF,
  parameter int unsigned          MEM_ADDR_BITS     = MEM_ADDR_BITS_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  if_stage_if.slave bus
);

  localparam logic [PC_WIDTH_LENGTH-1:0] PC_INC   = PC_WIDTH_LENGTH'(PC_STEP);
  localparam logic [PC_WIDTH_LENGTH-1:0] PC_RESET = PC_WIDTH_LENGTH'(RESET_VECTOR);

  pc_sel_e                    pc_sel_s;
  logic [PC_WIDTH_LENGTH-1:0] pc_d, pc_q;
  logic [PC_WIDTH_LENGTH-1:0] pc4_s;
  logic                       misalign_s;
  logic                       range_s;
  logic                       fault_s;
  logic                       load_s;
  logic [CNT_W-1:0]           cnt_d, cnt_q;

  // Sequential address; wraps naturally at the top of the address space.
  assign pc4_s = pc_q + PC_INC;

  assign misalign_s = (pc_q[1:0] != 2'b00);

  // Any set bit above the decoded window means no memory answers.
  generate
    if (MEM_ADDR_BITS < PC_WIDTH_LENGTH) begin : g_range
      assign range_s = (pc_q[PC_WIDTH_LENGTH-1:MEM_ADDR_BITS] != '0);
    end else begin : g_no_range
      assign range_s = 1'b0;
    end
  endgenerate

  assign fault_s = misalign_s | range_s;

  // PC source by priority; a redirect overrides a stall so the target is
  // not lost while the pipeline is frozen.
  always_comb begin
    pc_sel_s = PC_SEL_INC;
    if (bus.redirect_i) begin
      pc_sel_s = PC_SEL_TARGET;
    end else if (bus.stall_i) begin
      pc_sel_s = PC_SEL_HOLD;
    end else begin
      pc_sel_s = PC_SEL_INC;
    end
  end

  // Next PC value from the selected source.
  always_comb begin
    pc_d = pc_q;
    case (pc_sel_s)
      PC_SEL_TARGET: pc_d = bus.target_i;
      PC_SEL_HOLD:   pc_d = pc_q;
      PC_SEL_INC:    pc_d = pc4_s;
      default:       pc_d = PC_RESET;
    endcase
  end

  // IF/ID accepts a valid entry only when neither flushed nor stalled.
  always_comb begin
    load_s = 1'b0;
    if (!bus.flush_i && !bus.stall_i) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // Fetch counter next value.
  always_comb begin
    cnt_d = cnt_q;
    if (load_s) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // PC and fetch counter flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= PC_RESET;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  if_id_reg #(
    .PC_WIDTH_LENGTH  (PC_WIDTH_LENGTH),
    .INST_WIDTH_LENGTH(INST_WIDTH_LENGTH)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.flush_i),
    .stall_i (bus.stall_i),
    .fault_i (fault_s),
    .inst_i  (bus.inst_i),
    .pc_i    (pc_q),
    .pc4_i   (pc4_s),
    .valid_o (bus.ifid_valid_o),
    .inst_o  (bus.ifid_inst_o),
    .pc_o    (bus.ifid_pc_o),
    .pc4_o   (bus.ifid_pc4_o),
    .fault_o (bus.ifid_fault_o)
  );

  assign bus.pc_o        = pc_q;
  assign bus.fetch_cnt_o = cnt_q;

endmodule : if_stage

// File: tb/tb_if_stage.sv
// tb_if_stage: directed, table-driven bench for if_stage.
//   Instruction memory model: 256 words, word k holds 32'h1000_0000 | k,
//   addressed by pc_o[9:2]. Expected values in the table are hand-computed.
module tb_if_stage;

  typedef struct {
    string       name;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] target;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic [31:0] pc4;
    logic        fault;
    logic [31:0] cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [31:0] mem [0:255];
  vec_t        vecs [24];

  if_stage_if bus ();

  if_stage dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.inst_i = mem[bus.pc_o[9:2]];

  task automatic cmp1(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] pc, input logic valid,
                       input logic [31:0] inst, input logic [31:0] ipc, input logic [31:0] pc4,
                       input logic fault, input logic [31:0] cnt);
    n_vec = n_vec + 1;
    cmp1(nm, "pc",    bus.pc_o, pc);
    cmp1(nm, "valid", {31'd0, bus.ifid_valid_o}, {31'd0, valid});
    cmp1(nm, "inst",  bus.ifid_inst_o, inst);
    cmp1(nm, "ipc",   bus.ifid_pc_o, ipc);
    cmp1(nm, "pc4",   bus.ifid_pc4_o, pc4);
    cmp1(nm, "fault", {31'd0, bus.ifid_fault_o}, {31'd0, fault});
    cmp1(nm, "cnt",   bus.fetch_cnt_o, cnt);
  endtask

  task automatic setv(input int i, input string nm, input logic s, input logic f, input logic r,
                      input logic [31:0] t, input logic [31:0] pc, input logic v,
                      input logic [31:0] inst, input logic [31:0] ipc, input logic [31:0] pc4,
                      input logic flt, input logic [31:0] cnt);
    vecs[i] = '{nm, s, f, r, t, pc, v, inst, ipc, pc4, flt, cnt};
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 | k;

    //        name          st    fl    rd    target        pc            v     inst          ipc           pc4           flt   cnt
    setv( 0, "free0",      1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        1'b1, 32'h10000000, 32'h0,        32'h4,        1'b0, 32'd1);
    setv( 1, "free1",      1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        1'b1, 32'h10000001, 32'h4,        32'h8,        1'b0, 32'd2);
    setv( 2, "stall0",     1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        1'b1, 32'h10000001, 32'h4,        32'h8,        1'b0, 32'd2);
    setv( 3, "stall1",     1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        1'b1, 32'h10000001, 32'h4,        32'h8,        1'b0, 32'd2);
    setv( 4, "resume",     1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        1'b1, 32'h10000002, 32'h8,        32'hC,        1'b0, 32'd3);
    setv( 5, "free3",      1'b0, 1'b0, 1'b0, 32'h0,        32'h10,       1'b1, 32'h10000003, 32'hC,        32'h10,       1'b0, 32'd4);
    setv( 6, "free4",      1'b0, 1'b0, 1'b0, 32'h0,        32'h14,       1'b1, 32'h10000004, 32'h10,       32'h14,       1'b0, 32'd5);
    setv( 7, "free5",      1'b0, 1'b0, 1'b0, 32'h0,        32'h18,       1'b1, 32'h10000005, 32'h14,       32'h18,       1'b0, 32'd6);
    setv( 8, "free6",      1'b0, 1'b0, 1'b0, 32'h0,        32'h1C,       1'b1, 32'h10000006, 32'h18,       32'h1C,       1'b0, 32'd7);
    setv( 9, "free7",      1'b0, 1'b0, 1'b0, 32'h0,        32'h20,       1'b1, 32'h10000007, 32'h1C,       32'h20,       1'b0, 32'd8);
    setv(10, "br_flush",   1'b0, 1'b1, 1'b1, 32'h100,      32'h100,      1'b0, 32'h13,       32'h0,        32'h0,        1'b0, 32'd8);
    setv(11, "br_tgt",     1'b0, 1'b0, 1'b0, 32'h0,        32'h104,      1'b1, 32'h10000040, 32'h100,      32'h104,      1'b0, 32'd9);
    setv(12, "redir_mis",  1'b0, 1'b0, 1'b1, 32'h102,      32'h102,      1'b1, 32'h10000041, 32'h104,      32'h108,      1'b0, 32'd10);
    setv(13, "fault_mis",  1'b0, 1'b0, 1'b0, 32'h0,        32'h106,      1'b1, 32'h13,       32'h102,      32'h106,      1'b1, 32'd11);
    setv(14, "redir_oor",  1'b0, 1'b1, 1'b1, 32'h100000,   32'h100000,   1'b0, 32'h13,       32'h0,        32'h0,        1'b0, 32'd11);
    setv(15, "fault_oor",  1'b0, 1'b0, 1'b0, 32'h0,        32'h100004,   1'b1, 32'h13,       32'h100000,   32'h100004,   1'b1, 32'd12);
    setv(16, "redir_stl",  1'b1, 1'b0, 1'b1, 32'h200,      32'h200,      1'b1, 32'h13,       32'h100000,   32'h100004,   1'b1, 32'd12);
    setv(17, "stl_hold",   1'b1, 1'b0, 1'b0, 32'h0,        32'h200,      1'b1, 32'h13,       32'h100000,   32'h100004,   1'b1, 32'd12);
    setv(18, "stl_rel",    1'b0, 1'b0, 1'b0, 32'h0,        32'h204,      1'b1, 32'h10000080, 32'h200,      32'h204,      1'b0, 32'd13);
    setv(19, "flush_stl",  1'b1, 1'b1, 1'b0, 32'h0,        32'h204,      1'b0, 32'h13,       32'h0,        32'h0,        1'b0, 32'd13);
    setv(20, "after_fs",   1'b0, 1'b0, 1'b0, 32'h0,        32'h208,      1'b1, 32'h10000081, 32'h204,      32'h208,      1'b0, 32'd14);
    setv(21, "redir_top",  1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b1, 32'h10000082, 32'h208,      32'h20C,      1'b0, 32'd15);
    setv(22, "wrap",       1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h13,       32'hFFFFFFFC, 32'h0,        1'b1, 32'd16);
    setv(23, "after_wrap", 1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        1'b1, 32'h10000000, 32'h0,        32'h4,        1'b0, 32'd17);

    bus.stall_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.redirect_i = 1'b0;
    bus.target_i   = 32'h0;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'h0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      bus.stall_i    = vecs[i].stall;
      bus.flush_i    = vecs[i].flush;
      bus.redirect_i = vecs[i].redir;
      bus.target_i   = vecs[i].target;
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].pc, vecs[i].valid, vecs[i].inst, vecs[i].ipc,
            vecs[i].pc4, vecs[i].fault, vecs[i].cnt);
      @(negedge clk);
    end

    // Asynchronous reset asserted mid-cycle, checked before any further edge.
    bus.stall_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.redirect_i = 1'b0;
    bus.target_i   = 32'h0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'h0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_fetch", 32'h4, 1'b1, 32'h10000000, 32'h0, 32'h4, 1'b0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_if_stage
